// File: rtl/rv32i_packet_queue_pkg.sv
// Shared RV32I pipeline packet types: the packet carried between stages,
// its width, and the bubble value consumers substitute when a stage is empty.
package rv32i_packet;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode_t;

  typedef struct packed {
    logic [6:0]    funct7;
    logic [4:0]    rs2;
    logic [4:0]    rs1;
    logic [2:0]    funct3;
    logic [4:0]    rd;
    rv32i_opcode_t opcode;
  } rv32i_inst_t;

  typedef struct packed {
    logic [31:0] pc;
    rv32i_inst_t inst;
  } rv32i_packet_t;

  localparam int PACKET_W = $bits(rv32i_packet_t);

  // addi x0, x0, 0 at pc 0: the canonical bubble
  localparam rv32i_packet_t PACKET_NOP = '{
    pc:   32'h0,
    inst: '{funct7: 7'h0, rs2: 5'h0, rs1: 5'h0, funct3: 3'h0, rd: 5'h0, opcode: op_imm}
  };

endpackage

// File: rtl/rv32i_packet_queue.sv
// Flushable valid/ready circular-buffer queue between pipeline stages, with
// optional zero-latency fall-through when empty.
module rv32i_packet_queue
  import rv32i_packet::*;
#(
  parameter int WIDTH       = PACKET_W,
  parameter int DEPTH       = 2,
  parameter bit FALLTHROUGH = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_packet,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_packet,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // in_ready depends on stored state only, never on out_ready.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, bypass, push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    bypass   = FALLTHROUGH && empty;
    in_ready = (count_q != FULL_CNT);
    if (bypass) begin
      out_valid  = in_valid && !flush;
      out_packet = in_packet;
    end else begin
      out_valid  = !empty && !(FALLTHROUGH && flush);
      out_packet = mem_q[rd_ptr_q];
    end
    // A bypassed entry taken by the consumer is never stored.
    push = in_valid && in_ready && !(bypass && out_ready);
    pop  = !bypass && !empty && out_ready;
  end

  always_comb begin
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem_q[wr_ptr_q] <= in_packet;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_rv32i_packet_queue.sv
// Directed bench for rv32i_packet_queue across four configurations driven
// from one shared stimulus bus.
module tb_rv32i_packet_queue;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_packet;

  logic         irdy0, ov0, irdy1, ov1, irdy2, ov2, irdy3, ov3;
  logic [W-1:0] pk0, pk1, pk2, pk3;
  logic [2:0]   cnt0, cnt3;
  logic [1:0]   cnt1, cnt2;

  always #5 clk = ~clk;

  // dut 0: DEPTH=4, dut 1: DEPTH=3, dut 2: DEPTH=2, dut 3: DEPTH=4 fall-through
  rv32i_packet_queue #(.WIDTH(W), .DEPTH(4), .FALLTHROUGH(1'b0)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(irdy0),
    .in_packet(in_packet), .out_valid(ov0), .out_ready(out_ready),
    .out_packet(pk0), .count(cnt0));
  rv32i_packet_queue #(.WIDTH(W), .DEPTH(3), .FALLTHROUGH(1'b0)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(irdy1),
    .in_packet(in_packet), .out_valid(ov1), .out_ready(out_ready),
    .out_packet(pk1), .count(cnt1));
  rv32i_packet_queue #(.WIDTH(W), .DEPTH(2), .FALLTHROUGH(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(irdy2),
    .in_packet(in_packet), .out_valid(ov2), .out_ready(out_ready),
    .out_packet(pk2), .count(cnt2));
  rv32i_packet_queue #(.WIDTH(W), .DEPTH(4), .FALLTHROUGH(1'b1)) u_ft (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(irdy3),
    .in_packet(in_packet), .out_valid(ov3), .out_ready(out_ready),
    .out_packet(pk3), .count(cnt3));

  typedef struct {
    string        name;
    int           dut;
    logic         rst, flush, iv, ordy;
    logic [W-1:0] pkt;
    logic         chk;
    logic [2:0]   e_cnt;
    logic         e_irdy, e_ov, chk_pkt;
    logic [W-1:0] e_pkt;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  logic [2:0]   cur_cnt;
  logic         cur_irdy, cur_ov;
  logic [W-1:0] cur_pkt;
  int           sel;

  always_comb begin
    cur_cnt = cnt0; cur_irdy = irdy0; cur_ov = ov0; cur_pkt = pk0;
    case (sel)
      1: begin cur_cnt = {1'b0, cnt1}; cur_irdy = irdy1; cur_ov = ov1; cur_pkt = pk1; end
      2: begin cur_cnt = {1'b0, cnt2}; cur_irdy = irdy2; cur_ov = ov2; cur_pkt = pk2; end
      3: begin cur_cnt = cnt3; cur_irdy = irdy3; cur_ov = ov3; cur_pkt = pk3; end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input int dut, input logic r, input logic f,
                     input logic iv, input logic [W-1:0] pkt, input logic ordy,
                     input logic chk, input logic [2:0] e_cnt, input logic e_irdy,
                     input logic e_ov, input logic chk_pkt, input logic [W-1:0] e_pkt);
    vec_t v;
    v.name = name; v.dut = dut; v.rst = r; v.flush = f; v.iv = iv; v.pkt = pkt;
    v.ordy = ordy; v.chk = chk; v.e_cnt = e_cnt; v.e_irdy = e_irdy; v.e_ov = e_ov;
    v.chk_pkt = chk_pkt; v.e_pkt = e_pkt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [W-1:0] pkt, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_packet = pkt; out_ready = ordy;
  endtask

  task automatic reset_row();
    add("reset", 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    sel = 0;
    drive(1, 0, 0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 0, 0, 8'h00, 0);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      sel = d;
      #0;
      check($sformatf("reset_count_d%0d", d), W'(cur_cnt), 8'h0);
      check($sformatf("reset_in_ready_d%0d", d), W'(cur_irdy), 8'h1);
      check($sformatf("reset_out_valid_d%0d", d), W'(cur_ov), 8'h0);
    end

    // Fill DEPTH=4 with out_ready low, overflow attempt, then drain in order.
    add("fill0", 0, 0, 0, 1, 8'h11, 0, 1, 0, 1, 0, 0, 8'h00);
    add("fill1", 0, 0, 0, 1, 8'h22, 0, 1, 1, 1, 1, 1, 8'h11);
    add("fill2", 0, 0, 0, 1, 8'h33, 0, 1, 2, 1, 1, 1, 8'h11);
    add("fill3", 0, 0, 0, 1, 8'h44, 0, 1, 3, 1, 1, 1, 8'h11);
    add("fill_full", 0, 0, 0, 1, 8'h55, 0, 1, 4, 0, 1, 1, 8'h11);
    add("drain0", 0, 0, 0, 0, 8'h00, 1, 1, 4, 0, 1, 1, 8'h11);
    add("drain1", 0, 0, 0, 0, 8'h00, 1, 1, 3, 1, 1, 1, 8'h22);
    add("drain2", 0, 0, 0, 0, 8'h00, 1, 1, 2, 1, 1, 1, 8'h33);
    add("drain3", 0, 0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 1, 8'h44);
    add("drain_empty", 0, 0, 0, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00);
    reset_row();
    // DEPTH=2 full with push and pop in the same cycle: only the pop happens.
    add("fe_push0", 2, 0, 0, 1, 8'hA0, 0, 1, 0, 1, 0, 0, 8'h00);
    add("fe_push1", 2, 0, 0, 1, 8'hA1, 0, 1, 1, 1, 1, 1, 8'hA0);
    add("fe_both", 2, 0, 0, 1, 8'hA2, 1, 1, 2, 0, 1, 1, 8'hA0);
    add("fe_after", 2, 0, 0, 0, 8'h00, 0, 1, 1, 1, 1, 1, 8'hA1);
    add("fe_pop", 2, 0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 1, 8'hA1);
    add("fe_empty", 2, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00);
    reset_row();
    // Flush with 3 entries while both handshakes are offered.
    add("fl_push0", 0, 0, 0, 1, 8'hB0, 0, 1, 0, 1, 0, 0, 8'h00);
    add("fl_push1", 0, 0, 0, 1, 8'hB1, 0, 1, 1, 1, 1, 1, 8'hB0);
    add("fl_push2", 0, 0, 0, 1, 8'hB2, 0, 1, 2, 1, 1, 1, 8'hB0);
    add("fl_flush", 0, 0, 1, 1, 8'h77, 1, 1, 3, 1, 1, 1, 8'hB0);
    add("fl_after", 0, 0, 0, 1, 8'hAB, 0, 1, 0, 1, 0, 0, 8'h00);
    add("fl_first", 0, 0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 1, 8'hAB);
    add("fl_empty", 0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00);
    reset_row();
    // Fall-through: pass-through, stall-and-store, flush masking.
    add("ft_pass", 3, 0, 0, 1, 8'h5A, 1, 1, 0, 1, 1, 1, 8'h5A);
    add("ft_idle", 3, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00);
    add("ft_stall", 3, 0, 0, 1, 8'h5A, 0, 1, 0, 1, 1, 1, 8'h5A);
    add("ft_stored", 3, 0, 0, 0, 8'h00, 0, 1, 1, 1, 1, 1, 8'h5A);
    add("ft_flush_full", 3, 0, 1, 1, 8'hC3, 0, 1, 1, 1, 0, 0, 8'h00);
    add("ft_flushed", 3, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00);
    add("ft_flush_empty", 3, 0, 1, 1, 8'hC4, 1, 1, 0, 1, 0, 0, 8'h00);
    add("ft_not_stored", 3, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00);
    reset_row();
    // Reset pulse with 2 entries held.
    add("rm_push0", 0, 0, 0, 1, 8'hD0, 0, 1, 0, 1, 0, 0, 8'h00);
    add("rm_push1", 0, 0, 0, 1, 8'hD1, 0, 1, 1, 1, 1, 1, 8'hD0);
    add("rm_rst", 0, 1, 0, 0, 8'h00, 0, 1, 2, 1, 1, 1, 8'hD0);
    add("rm_after", 0, 0, 0, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00);
    add("rm_stale", 0, 0, 0, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      sel = vecs[i].dut;
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pkt, vecs[i].ordy);
      @(negedge clk);
      if (vecs[i].chk) begin
        check({vecs[i].name, "_count"}, W'(cur_cnt), W'(vecs[i].e_cnt));
        check({vecs[i].name, "_in_ready"}, W'(cur_irdy), W'(vecs[i].e_irdy));
        check({vecs[i].name, "_out_valid"}, W'(cur_ov), W'(vecs[i].e_ov));
        if (vecs[i].chk_pkt) check({vecs[i].name, "_out_packet"}, cur_pkt, vecs[i].e_pkt);
      end
      @(posedge clk);
      #1;
    end

    // Wrap-around on DEPTH=3: one-cycle prime, then push and pop every cycle.
    sel = 1;
    drive(1, 0, 0, 8'h00, 0);
    @(posedge clk);
    #1;
    for (int k = 0; k <= 10; k++) begin
      logic [W-1:0] v;
      v = W'(k * 17 + 3);
      drive(0, 0, (k < 10), v, 1);
      if (k < 10) exp_q.push_back(v);
      @(negedge clk);
      if (k == 0) begin
        check("wrap_prime_count", W'(cur_cnt), 8'h0);
        check("wrap_prime_valid", W'(cur_ov), 8'h0);
      end else begin
        check($sformatf("wrap_count_%0d", k), W'(cur_cnt), 8'h1);
        check($sformatf("wrap_valid_%0d", k), W'(cur_ov), 8'h1);
        check($sformatf("wrap_packet_%0d", k), cur_pkt, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 8'h00, 0);
    @(negedge clk);
    check("wrap_end_count", W'(cur_cnt), 8'h0);
    check("wrap_end_valid", W'(cur_ov), 8'h0);
    check("wrap_queue_drained", W'(exp_q.size()), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
